// File: rtl/apb_arb_master.sv
`timescale 1ns/1ps
// apb_arb_master: two-requester round-robin APB master.
// Requester handshake: reqN_valid is raised with stable write/addr/wdata and
// held until reqN_done pulses for one cycle. reqN_rdata/reqN_err are valid
// with that pulse and hold until the next completion for the same requester.
// The requester drops valid or presents its next request at the edge after
// it sees done; a requester whose done is high is not eligible for a grant.
module apb_arb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q;
  logic                last_grant_q;   // also identifies the requester being served
  logic [CNT_W-1:0]    wait_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                selx_q;
  logic                enable_q;
  logic                done0_q, done1_q;
  logic                err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                elig0, elig1, any_elig;
  logic                grant_d;
  logic                finish_d;
  logic                err_d;
  logic [DATA_W-1:0]   rdata_d;

  // Arbitration and completion decode for the current cycle.
  always_comb begin
    elig0    = req0_valid & ~done0_q;
    elig1    = req1_valid & ~done1_q;
    any_elig = elig0 | elig1;
    grant_d  = last_grant_q;
    if (elig0 && elig1) grant_d = ~last_grant_q;
    else if (elig0)     grant_d = 1'b0;
    else if (elig1)     grant_d = 1'b1;
    // Timeout only fires while the slave is still holding off.
    finish_d = P_ready | ((TIMEOUT > 0) && (wait_q == CNT_LAST));
    err_d    = P_ready ? P_slverr : 1'b1;
    rdata_d  = (P_ready && !write_q) ? P_rdata : '0;
  end

  // Transfer FSM with all bus and requester outputs registered.
  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      wait_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      selx_q       <= 1'b0;
      enable_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_elig) begin
            last_grant_q <= grant_d;
            addr_q       <= grant_d ? req1_addr  : req0_addr;
            wdata_q      <= grant_d ? req1_wdata : req0_wdata;
            write_q      <= grant_d ? req1_write : req0_write;
            selx_q       <= 1'b1;
            enable_q     <= 1'b0;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          enable_q <= 1'b1;
          wait_q   <= '0;
          state_q  <= S_ACCESS;
        end
        S_ACCESS: begin
          if (finish_d) begin
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            state_q  <= S_IDLE;
            if (last_grant_q) begin
              done1_q  <= 1'b1;
              err1_q   <= err_d;
              rdata1_q <= rdata_d;
            end else begin
              done0_q  <= 1'b1;
              err0_q   <= err_d;
              rdata0_q <= rdata_d;
            end
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign P_addr     = addr_q;
  assign P_wdata    = wdata_q;
  assign P_write    = write_q;
  assign P_selx     = selx_q;
  assign P_enable   = enable_q;
  assign req0_done  = done0_q;
  assign req0_rdata = rdata0_q;
  assign req0_err   = err0_q;
  assign req1_done  = done1_q;
  assign req1_rdata = rdata1_q;
  assign req1_err   = err1_q;

endmodule

// File: tb/tb_apb_arb_master.sv
`timescale 1ns/1ps
// Bench for apb_arb_master: directed vector table, hand-written corner
// sequences and a randomized two-requester run against a transaction model.
// The attached slave decodes its behaviour from the address:
//   addr[3:0] memory index, addr[5] error region (slverr, writes dropped),
//   addr[7:6] number of ACCESS wait cycles before P_ready.
module tb_apb_arb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          P_clk = 1'b0;
  logic          P_rst = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req0_done, req0_err;
  logic [DW-1:0] req0_rdata;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req1_done, req1_err;
  logic [DW-1:0] req1_rdata;
  logic [AW-1:0] P_addr;
  logic          P_selx, P_enable, P_write;
  logic [DW-1:0] P_wdata;
  logic          P_ready, P_slverr;
  logic [DW-1:0] P_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 P_clk = ~P_clk;

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
    .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [16];
  int            acc_cnt = 0;
  logic          stuck = 1'b0;
  logic          ready_tie = 1'b0;
  logic          mem_clr = 1'b1;

  always @(posedge P_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
    end else if (P_selx && P_enable && P_ready && P_write && !P_addr[5]) begin
      mem[P_addr[3:0]] <= P_wdata;
    end
    if (P_selx && P_enable) acc_cnt <= acc_cnt + 1;
    else                    acc_cnt <= 0;
  end

  assign P_ready  = !stuck && (ready_tie ||
                    (P_selx && P_enable && (acc_cnt >= int'(P_addr[7:6]))));
  assign P_slverr = P_addr[5];
  assign P_rdata  = mem[P_addr[3:0]];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic get_done(input int id);
    return (id != 0) ? req1_done : req0_done;
  endfunction
  function automatic logic [DW-1:0] get_rdata(input int id);
    return (id != 0) ? req1_rdata : req0_rdata;
  endfunction
  function automatic logic get_err(input int id);
    return (id != 0) ? req1_err : req0_err;
  endfunction

  // Waits (at negedges) for requester id's done pulse, at most budget cycles.
  task automatic wait_done(input int id, input int budget, output logic got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge P_clk);
      if (get_done(id)) got = 1'b1;
    end
  endtask

  // ---------------- protocol monitor ----------------
  logic          mon_en = 1'b0;
  logic          prv_selx = 1'b0, prv_en = 1'b0, prv_write = 1'b0;
  logic [AW-1:0] prv_addr = '0;
  logic [DW-1:0] prv_wdata = '0;

  always @(negedge P_clk) begin
    if (mon_en) begin
      check("done_exclusive", req0_done & req1_done, 1'b0);
      if (prv_selx && !prv_en) check("setup_to_access", {P_selx, P_enable}, 2'b11);
      if (prv_selx && prv_en && P_selx) begin
        check("access_enable", P_enable, 1'b1);
        check("access_addr", P_addr, prv_addr);
        check("access_write", P_write, prv_write);
        check("access_wdata", P_wdata, prv_wdata);
      end
    end
    prv_selx  <= P_selx;
    prv_en    <= P_enable;
    prv_write <= P_write;
    prv_addr  <= P_addr;
    prv_wdata <= P_wdata;
  end

  // ---------------- scoreboard ----------------
  logic          sb_on = 1'b0;
  logic [DW:0]   exp0_q[$];
  logic [DW:0]   exp1_q[$];
  int            order_q[$];

  task automatic sb_pop(input int id);
    logic [DW:0] e;
    int o;
    if (order_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sb_order: done from req%0d, no completion expected", id);
    end else begin
      o = order_q.pop_front();
      check("sb_order", id, o);
    end
    if ((id == 0 && exp0_q.size() == 0) || (id == 1 && exp1_q.size() == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL sb_result: done from req%0d with empty expected queue", id);
    end else begin
      e = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
      check($sformatf("sb_result_req%0d", id), {get_err(id), get_rdata(id)}, e);
    end
  endtask

  always @(negedge P_clk) begin
    if (sb_on) begin
      if (req0_done) sb_pop(0);
      if (req1_done) sb_pop(1);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stk;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t          vecs[11];
  logic [DW-1:0] last_rd[2];
  logic          last_err[2];

  // One isolated transfer from a quiet IDLE; latency is counted in cycles
  // from raising valid to seeing done.
  task automatic single_xfer(input string tag, input vec_t v);
    int   lat;
    logic got, other_done;
    int   oth;
    oth = 1 - v.id;
    stuck = v.stk;
    set_req(v.id, 1'b1, v.wr, v.addr, v.wdata);
    lat = 0; got = 1'b0; other_done = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge P_clk);
      lat++;
      if (get_done(oth)) other_done = 1'b1;
      if (get_done(v.id)) got = 1'b1;
    end
    check({tag, "_done"}, got, 1'b1);
    if (got) begin
      check({tag, "_rdata"}, get_rdata(v.id), v.exp_rd);
      check({tag, "_err"}, get_err(v.id), v.exp_err);
      check({tag, "_latency"}, lat, v.exp_lat);
    end
    check({tag, "_other_done"}, other_done, 1'b0);
    check({tag, "_other_hold"}, {get_err(oth), get_rdata(oth)}, {last_err[oth], last_rd[oth]});
    last_rd[v.id]  = v.exp_rd;
    last_err[v.id] = v.exp_err;
    set_req(v.id, 1'b0, 1'b0, '0, '0);
    stuck = 1'b0;
    @(negedge P_clk);
    check({tag, "_done_one_cycle"}, get_done(v.id), 1'b0);
  endtask

  // ---------------- random stimulus ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          stim0_q[$];
  req_t          stim1_q[$];
  logic [DW-1:0] ref_mem[16];

  task automatic drive_stream(input int id);
    int   n;
    req_t r;
    logic got;
    n = (id == 0) ? stim0_q.size() : stim1_q.size();
    for (int k = 0; k < n; k++) begin
      r = (id == 0) ? stim0_q[k] : stim1_q[k];
      set_req(id, 1'b1, r.wr, r.addr, r.wdata);
      wait_done(id, 80, got);
      check($sformatf("rand_done_req%0d_%0d", id, k), got, 1'b1);
      if (!got) break;
    end
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [1:0] w;
    logic       e;
    logic [3:0] idx;
    w     = 2'($urandom_range(0, 3));
    e     = ($urandom_range(0, 3) == 0);
    idx   = 4'($urandom_range(0, 7));
    r.wr    = 1'($urandom_range(0, 1));
    r.addr  = {24'h0, w, e, 1'b0, idx};
    r.wdata = $urandom;
    return r;
  endfunction

  // Transaction-level model: round-robin over pending request lists, then
  // memory semantics of the slave.
  task automatic build_model();
    int   i0, i1, pick, last;
    req_t r;
    logic [DW:0] e;
    i0 = 0; i1 = 0; last = 1;
    while (i0 < stim0_q.size() || i1 < stim1_q.size()) begin
      if (i0 < stim0_q.size() && i1 < stim1_q.size()) pick = (last == 1) ? 0 : 1;
      else pick = (i0 < stim0_q.size()) ? 0 : 1;
      if (pick == 0) begin r = stim0_q[i0]; i0++; end
      else begin r = stim1_q[i1]; i1++; end
      if (r.wr) begin
        if (!r.addr[5]) ref_mem[r.addr[3:0]] = r.wdata;
        e = {r.addr[5], {DW{1'b0}}};
      end else begin
        e = {r.addr[5], ref_mem[r.addr[3:0]]};
      end
      if (pick == 0) exp0_q.push_back(e);
      else           exp1_q.push_back(e);
      order_q.push_back(pick);
      last = pick;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic got;
    int   n0, n1;

    vecs[0]  = '{1, 1'b0, 32'h01, 32'h0,      1'b0, 32'h7,    1'b0, 3};
    vecs[1]  = '{0, 1'b1, 32'h22, 32'h55,     1'b0, 32'h0,    1'b1, 3};
    vecs[2]  = '{1, 1'b0, 32'h02, 32'h0,      1'b0, 32'h1002, 1'b0, 3};
    vecs[3]  = '{0, 1'b0, 32'hC2, 32'h0,      1'b0, 32'h1002, 1'b0, 6};
    vecs[4]  = '{1, 1'b1, 32'h43, 32'hDEAD,   1'b0, 32'h0,    1'b0, 4};
    vecs[5]  = '{0, 1'b0, 32'h83, 32'h0,      1'b0, 32'hDEAD, 1'b0, 5};
    vecs[6]  = '{1, 1'b0, 32'h21, 32'h0,      1'b0, 32'h7,    1'b1, 3};
    vecs[7]  = '{0, 1'b0, 32'h04, 32'h0,      1'b1, 32'h0,    1'b1, 18};
    vecs[8]  = '{1, 1'b0, 32'hE3, 32'h0,      1'b0, 32'hDEAD, 1'b1, 6};
    vecs[9]  = '{0, 1'b1, 32'h05, 32'h1234,   1'b0, 32'h0,    1'b0, 3};
    vecs[10] = '{1, 1'b0, 32'h05, 32'h0,      1'b0, 32'h1234, 1'b0, 3};

    // Reset: every output zero.
    repeat (3) @(negedge P_clk);
    check("rst_p_addr", P_addr, '0);
    check("rst_p_wdata", P_wdata, '0);
    check("rst_ctrl", {P_write, P_selx, P_enable, req0_done, req0_err, req1_done, req1_err}, 7'b0);
    check("rst_req0_rdata", req0_rdata, '0);
    check("rst_req1_rdata", req1_rdata, '0);
    P_rst = 1'b0;
    mem_clr = 1'b0;
    mon_en = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0; last_err[0] = 1'b0; last_err[1] = 1'b0;

    // Tied-ready write, cycle by cycle.
    ready_tie = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h1, 32'h7);
    @(negedge P_clk);
    check("tie_setup", {P_selx, P_enable, P_write, req0_done}, 4'b1010);
    check("tie_addr", P_addr, 32'h1);
    check("tie_wdata", P_wdata, 32'h7);
    @(negedge P_clk);
    check("tie_access", {P_selx, P_enable, req0_done}, 3'b110);
    @(negedge P_clk);
    check("tie_done", {P_selx, P_enable, req0_done, req0_err, req1_done}, 5'b00100);
    check("tie_rdata", req0_rdata, '0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    ready_tie = 1'b0;
    @(negedge P_clk);
    check("tie_done_one_cycle", req0_done, 1'b0);
    check("tie_slave_mem1", mem[1], 32'h7);

    // Directed table.
    for (int i = 0; i < 11; i++) single_xfer($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of ACCESS, then both requesters contend.
    stuck = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h3, 32'h0);
    for (int c = 0; c < 10 && !P_enable; c++) @(negedge P_clk);
    check("rstmid_in_access", {P_selx, P_enable}, 2'b11);
    P_rst = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h6, 32'h0);
    @(negedge P_clk);
    check("rstmid_p_addr", P_addr, '0);
    check("rstmid_ctrl", {P_write, P_selx, P_enable, req0_done, req0_err, req1_done, req1_err}, 7'b0);
    check("rstmid_rdata", {req0_rdata, req1_rdata}, '0);
    P_rst = 1'b0;
    stuck = 1'b0;
    @(negedge P_clk);
    check("rstmid_first_grant", {P_selx, P_enable, req0_done, req1_done}, 4'b1000);
    check("rstmid_first_addr", P_addr, 32'h3);
    wait_done(0, 20, got);
    check("rstmid_req0_done", got, 1'b1);
    check("rstmid_req0_result", {req0_err, req0_rdata}, {1'b0, 32'hDEAD});
    check("rstmid_req1_not_done", req1_done, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    wait_done(1, 20, got);
    check("rstmid_req1_done", got, 1'b1);
    check("rstmid_req1_result", {req1_err, req1_rdata}, {1'b0, 32'h1006});
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge P_clk);

    // Randomized contention against the transaction model.
    for (int pass = 0; pass < 3; pass++) begin
      P_rst = 1'b1;
      repeat (2) @(negedge P_clk);
      P_rst = 1'b0;
      ref_mem = mem;
      stim0_q.delete(); stim1_q.delete();
      n0 = $urandom_range(5, 12);
      n1 = $urandom_range(5, 12);
      for (int k = 0; k < n0; k++) stim0_q.push_back(rand_req());
      for (int k = 0; k < n1; k++) stim1_q.push_back(rand_req());
      build_model();
      sb_on = 1'b1;
      fork
        drive_stream(0);
        drive_stream(1);
      join
      repeat (2) @(negedge P_clk);
      sb_on = 1'b0;
      check($sformatf("rand%0d_exp0_left", pass), exp0_q.size(), 0);
      check($sformatf("rand%0d_exp1_left", pass), exp1_q.size(), 0);
      check($sformatf("rand%0d_order_left", pass), order_q.size(), 0);
      exp0_q.delete(); exp1_q.delete(); order_q.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
